// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared index type and round-robin helpers for mem_arbiter_rr
package arb_pkg;

    localparam int IDX_MAX_W = 8;

    typedef logic [IDX_MAX_W-1:0] idx_t;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Successor of cur in a ring of n masters.
    function automatic idx_t rr_next(input idx_t cur, input int n);
        return (int'(cur) >= n - 1) ? '0 : cur + idx_t'(1);
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// rtl/arb_id_fifo.sv - in-order FIFO of granted master indices awaiting read data
module arb_id_fifo
    import arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       res_n,
    input  logic                       push,
    input  idx_t                       din,
    input  logic                       pop,
    output idx_t                       dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    idx_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - N-master round-robin arbiter onto one pipelined memory port
module mem_arbiter_rr
    import arb_pkg::*;
#(
    parameter int NUM_MASTERS     = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                            clk,
    input  logic                            res_n,
    input  logic [NUM_MASTERS-1:0]          m_req,
    input  logic [NUM_MASTERS-1:0]          m_we,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_be,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
    output logic [NUM_MASTERS-1:0]          m_gnt,
    output logic [NUM_MASTERS-1:0]          m_rvalid,
    output logic [DATA_W-1:0]               m_rdata,
    output logic                            s_req,
    output logic                            s_we,
    output logic [DATA_W/8-1:0]             s_be,
    output logic [ADDR_W-1:0]               s_addr,
    output logic [DATA_W-1:0]               s_wdata,
    input  logic                            s_gnt,
    input  logic                            s_rvalid,
    input  logic [DATA_W-1:0]               s_rdata,
    output logic                            err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    idx_t             rr_ptr;
    idx_t             sel_q;
    idx_t             sel;
    idx_t             pick;
    idx_t             head;
    logic             lock_q;
    logic             found;
    logic             hs;
    logic             push;
    logic             pop;
    logic             err_set;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    function automatic logic bit_at(input logic [NUM_MASTERS-1:0] v, input idx_t i);
        logic b;
        b = 1'b0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (idx_t'(j) == i) begin
                b = v[j];
            end
        end
        return b;
    endfunction

    // Scan starts just after the last winner; rr_ptr itself is visited last.
    always_comb begin
        idx_t cand;
        found = 1'b0;
        pick  = rr_ptr;
        cand  = rr_ptr;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = rr_next(cand, NUM_MASTERS);
            if (!found && bit_at(m_req, cand)) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign sel     = lock_q ? sel_q : pick;
    assign s_req   = res_n & bit_at(m_req, sel) & (fifo_count < CNT_W'(MAX_OUTSTANDING));
    assign hs      = s_req & s_gnt;
    assign push    = hs & ~s_we & ~fifo_full;
    assign pop     = res_n & s_rvalid & ~fifo_empty;
    assign err_set = (s_rvalid & fifo_empty) | (lock_q & ~bit_at(m_req, sel_q));
    assign m_rdata = s_rdata;

    always_comb begin
        s_we     = 1'b0;
        s_be     = '0;
        s_addr   = '0;
        s_wdata  = '0;
        m_gnt    = '0;
        m_rvalid = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (idx_t'(i) == sel) begin
                s_we     = m_we[i];
                s_be     = m_be[i*BE_W +: BE_W];
                s_addr   = m_addr[i*ADDR_W +: ADDR_W];
                s_wdata  = m_wdata[i*DATA_W +: DATA_W];
                m_gnt[i] = hs;
            end
            if (idx_t'(i) == head) begin
                m_rvalid[i] = pop;
            end
        end
    end

    // A stalled request freezes the selection until it is granted or withdrawn.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            rr_ptr <= idx_t'(NUM_MASTERS - 1);
            sel_q  <= '0;
            lock_q <= 1'b0;
            err    <= 1'b0;
        end else begin
            err <= err_set;
            if (hs) begin
                rr_ptr <= sel;
                lock_q <= 1'b0;
            end else if (s_req) begin
                lock_q <= 1'b1;
                sel_q  <= sel;
            end else if (lock_q) begin
                lock_q <= 1'b0;
            end
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .res_n (res_n),
        .push  (push),
        .din   (sel),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb/tb_mem_arbiter_rr.sv - self-checking bench for mem_arbiter_rr
module tb_mem_arbiter_rr;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 2;
    localparam int BW = DW / 8;

    logic              clk = 1'b0;
    logic              res_n = 1'b0;
    logic [NM-1:0]     m_req = '0;
    logic [NM-1:0]     m_we = '0;
    logic [NM*BW-1:0]  m_be = '1;
    logic [NM*AW-1:0]  m_addr;
    logic [NM*DW-1:0]  m_wdata;
    logic [NM-1:0]     m_gnt;
    logic [NM-1:0]     m_rvalid;
    logic [DW-1:0]     m_rdata;
    logic              s_req;
    logic              s_we;
    logic [BW-1:0]     s_be;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic              s_gnt = 1'b0;
    logic              s_rvalid = 1'b0;
    logic [DW-1:0]     s_rdata = '0;
    logic              err;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    mem_arbiter_rr #(
        .NUM_MASTERS     (NM),
        .ADDR_W          (AW),
        .DATA_W          (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk      (clk),
        .res_n    (res_n),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_be     (m_be),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .s_req    (s_req),
        .s_we     (s_we),
        .s_be     (s_be),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_gnt    (s_gnt),
        .s_rvalid (s_rvalid),
        .s_rdata  (s_rdata),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic cycle(input logic [NM-1:0] req, input logic [NM-1:0] we,
                         input logic gnt, input logic rv, input logic [DW-1:0] rd);
        @(negedge clk);
        m_req    = req;
        m_we     = we;
        s_gnt    = gnt;
        s_rvalid = rv;
        s_rdata  = rd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        res_n = 1'b0;
        m_req = '0; m_we = '0; s_gnt = 1'b0; s_rvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        res_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        m_req = '1; s_gnt = 1'b1; s_rvalid = 1'b1;
        @(negedge clk);
        n_cmp++; if (s_req !== 1'b0) begin n_bad++; $display("FAIL reset_s_req got %b want 0", s_req); end
        n_cmp++; if (m_gnt !== 4'b0) begin n_bad++; $display("FAIL reset_m_gnt got %b want 0000", m_gnt); end
        n_cmp++; if (m_rvalid !== 4'b0) begin n_bad++; $display("FAIL reset_m_rvalid got %b want 0000", m_rvalid); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
        m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0;
        @(negedge clk);
        res_n = 1'b1;
    endtask

    task automatic test_single_reads();
        int h;
        m_addr[2*AW +: AW] = 32'h100;
        cycle(4'b0100, 4'b0000, 1'b1, 1'b0, '0);
        n_cmp++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin n_bad++; $display("FAIL single_req0 got req=%b addr=%h want 1/00000100", s_req, s_addr); end
        n_cmp++; if (m_gnt !== 4'b0100) begin n_bad++; $display("FAIL single_gnt0 got %b want 0100", m_gnt); end
        exp_q.push_back(2);
        m_addr[2*AW +: AW] = 32'h104;
        h = exp_q.pop_front();
        cycle(4'b0100, 4'b0000, 1'b1, 1'b1, 32'hA5A5A5A5);
        n_cmp++; if (s_addr !== 32'h104 || m_gnt !== 4'b0100) begin n_bad++; $display("FAIL single_gnt1 got addr=%h gnt=%b want 00000104/0100", s_addr, m_gnt); end
        n_cmp++; if (m_rvalid !== 4'(1 << h) || m_rdata !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL single_rv0 got %b/%h want %b/a5a5a5a5", m_rvalid, m_rdata, 4'(1 << h)); end
        exp_q.push_back(2);
        h = exp_q.pop_front();
        cycle(4'b0000, 4'b0000, 1'b1, 1'b1, 32'h5A5A5A5A);
        n_cmp++; if (m_rvalid !== 4'(1 << h) || m_rdata !== 32'h5A5A5A5A || m_gnt !== 4'b0) begin n_bad++; $display("FAIL single_rv1 got %b/%h gnt=%b want %b/5a5a5a5a", m_rvalid, m_rdata, m_gnt, 4'(1 << h)); end
        cycle(4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_err got %b want 0", err); end
        m_addr[2*AW +: AW] = 32'h1020;
    endtask

    task automatic test_round_robin();
        logic          rv;
        int            h;
        logic [DW-1:0] d;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            rv = (exp_q.size() > 0);
            h  = rv ? exp_q.pop_front() : 0;
            d  = $urandom;
            cycle((k < 8) ? 4'hF : 4'h0, 4'h0, 1'b1, rv, d);
            if (k < 8) begin
                n_cmp++; if (m_gnt !== 4'(1 << (k % 4))) begin n_bad++; $display("FAIL rr_gnt[%0d] got %b want %b", k, m_gnt, 4'(1 << (k % 4))); end
                exp_q.push_back(k % 4);
            end
            if (rv) begin
                n_cmp++; if (m_rvalid !== 4'(1 << h) || m_rdata !== d) begin n_bad++; $display("FAIL rr_rv[%0d] got %b/%h want %b/%h", k, m_rvalid, m_rdata, 4'(1 << h), d); end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rr_drain got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_lock();
        for (int c = 0; c < 3; c++) begin
            cycle((c == 0) ? 4'b0010 : 4'b0011, 4'b0011, 1'b0, 1'b0, '0);
            n_cmp++; if (s_req !== 1'b1 || s_addr !== 32'h1010 || s_we !== 1'b1 || m_gnt !== 4'b0) begin
                n_bad++; $display("FAIL lock_hold[%0d] got req=%b addr=%h we=%b gnt=%b want 1/00001010/1/0000", c, s_req, s_addr, s_we, m_gnt);
            end
        end
        cycle(4'b0011, 4'b0011, 1'b1, 1'b0, '0);
        n_cmp++; if (m_gnt !== 4'b0010 || s_wdata !== 32'hD000_0001) begin n_bad++; $display("FAIL lock_gnt got %b/%h want 0010/d0000001", m_gnt, s_wdata); end
        cycle(4'b0001, 4'b0001, 1'b1, 1'b0, '0);
        n_cmp++; if (m_gnt !== 4'b0001 || s_wdata !== 32'hD000_0000 || s_be !== 4'hF) begin n_bad++; $display("FAIL lock_next got %b/%h/%h want 0001/d0000000/f", m_gnt, s_wdata, s_be); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL lock_err got %b want 0", err); end
    endtask

    task automatic test_full();
        int h;
        cycle(4'b0001, 4'b0000, 1'b1, 1'b0, '0);
        n_cmp++; if (m_gnt !== 4'b0001) begin n_bad++; $display("FAIL full_gnt0 got %b want 0001", m_gnt); end
        exp_q.push_back(0);
        cycle(4'b0100, 4'b0000, 1'b1, 1'b0, '0);
        n_cmp++; if (m_gnt !== 4'b0100) begin n_bad++; $display("FAIL full_gnt2 got %b want 0100", m_gnt); end
        exp_q.push_back(2);
        cycle(4'b1000, 4'b1000, 1'b1, 1'b0, '0);
        n_cmp++; if (s_req !== 1'b0 || m_gnt !== 4'b0) begin n_bad++; $display("FAIL full_block got req=%b gnt=%b want 0/0000", s_req, m_gnt); end
        h = exp_q.pop_front();
        cycle(4'b1000, 4'b1000, 1'b1, 1'b1, 32'h1111_0000);
        n_cmp++; if (s_req !== 1'b0 || m_rvalid !== 4'(1 << h)) begin n_bad++; $display("FAIL full_nobypass got req=%b rv=%b want 0/%b", s_req, m_rvalid, 4'(1 << h)); end
        cycle(4'b1000, 4'b1000, 1'b1, 1'b0, '0);
        n_cmp++; if (s_req !== 1'b1 || m_gnt !== 4'b1000) begin n_bad++; $display("FAIL full_release got req=%b gnt=%b want 1/1000", s_req, m_gnt); end
        h = exp_q.pop_front();
        cycle(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h2222_0000);
        n_cmp++; if (m_rvalid !== 4'(1 << h) || m_rdata !== 32'h2222_0000) begin n_bad++; $display("FAIL full_rv2 got %b/%h want %b/22220000", m_rvalid, m_rdata, 4'(1 << h)); end
    endtask

    task automatic test_interleave();
        int h;
        cycle(4'b0001, 4'b0000, 1'b1, 1'b0, '0);
        n_cmp++; if (m_gnt !== 4'b0001) begin n_bad++; $display("FAIL il_gnt0 got %b want 0001", m_gnt); end
        exp_q.push_back(0);
        h = exp_q.pop_front();
        cycle(4'b1000, 4'b1000, 1'b1, 1'b1, 32'h3333_0000);
        n_cmp++; if (m_gnt !== 4'b1000 || m_rvalid !== 4'(1 << h)) begin n_bad++; $display("FAIL il_wr3 got gnt=%b rv=%b want 1000/%b", m_gnt, m_rvalid, 4'(1 << h)); end
        cycle(4'b0100, 4'b0000, 1'b1, 1'b0, '0);
        n_cmp++; if (m_gnt !== 4'b0100 || m_rvalid !== 4'b0) begin n_bad++; $display("FAIL il_gnt2 got gnt=%b rv=%b want 0100/0000", m_gnt, m_rvalid); end
        exp_q.push_back(2);
        h = exp_q.pop_front();
        cycle(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h4444_0000);
        n_cmp++; if (m_rvalid !== 4'(1 << h) || m_rdata !== 32'h4444_0000) begin n_bad++; $display("FAIL il_rv2 got %b/%h want %b/44440000", m_rvalid, m_rdata, 4'(1 << h)); end
    endtask

    task automatic test_errors();
        cycle(4'b0000, 4'b0000, 1'b0, 1'b1, 32'hDEAD_BEEF);
        n_cmp++; if (m_rvalid !== 4'b0) begin n_bad++; $display("FAIL err_empty_rv got %b want 0000", m_rvalid); end
        cycle(4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_empty_pulse got %b want 1", err); end
        cycle(4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_empty_clear got %b want 0", err); end
        cycle(4'b0010, 4'b0000, 1'b0, 1'b0, '0);
        cycle(4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        n_cmp++; if (s_req !== 1'b0 || m_gnt !== 4'b0) begin n_bad++; $display("FAIL err_drop_req got req=%b gnt=%b want 0/0000", s_req, m_gnt); end
        cycle(4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_drop_pulse got %b want 1", err); end
        cycle(4'b0001, 4'b0000, 1'b1, 1'b0, '0);
        n_cmp++; if (m_gnt !== 4'b0001) begin n_bad++; $display("FAIL err_rearb got %b want 0001", m_gnt); end
        exp_q.push_back(0);
    endtask

    task automatic test_reset_mid();
        cycle(4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        #2;
        res_n    = 1'b0;
        m_req    = '1;
        s_gnt    = 1'b1;
        s_rvalid = 1'b1;
        #1;
        n_cmp++; if (s_req !== 1'b0 || m_gnt !== 4'b0 || m_rvalid !== 4'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset got req=%b gnt=%b rv=%b err=%b want all 0", s_req, m_gnt, m_rvalid, err);
        end
        @(negedge clk);
        m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0;
        @(negedge clk);
        res_n = 1'b1;
        exp_q.delete();
        cycle(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h5555_0000);
        n_cmp++; if (m_rvalid !== 4'b0) begin n_bad++; $display("FAIL mid_stale_rv got %b want 0000", m_rvalid); end
        cycle(4'hF, 4'h0, 1'b1, 1'b0, '0);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL mid_stale_err got %b want 1", err); end
        n_cmp++; if (m_gnt !== 4'b0001) begin n_bad++; $display("FAIL mid_rr_ptr got %b want 0001", m_gnt); end
    endtask

    initial begin
        for (int i = 0; i < NM; i++) begin
            m_addr[i*AW +: AW]  = 32'h1000 + 32'(16 * i);
            m_wdata[i*DW +: DW] = 32'hD000_0000 + 32'(i);
        end
        test_reset();
        test_single_reads();
        test_round_robin();
        test_lock();
        test_full();
        test_interleave();
        test_errors();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
